matrix_stream_loader: RTL
=========================

// Module: matrix_stream_loader
// PURPOSE
//  Upstream stage for the sequential matrix multiplier. Accepts M-bit elements over a valid/ready
//  stream, assembles two NxN operand matrices (X then Y, row-major) into flat buses, then holds
//  them stable while the multiplier runs. Pulses mat_start when both are complete, and releases
//  the buffers on mat_ack from the consumer.
// PARAMETERS
//  N  3   matrix dimension (N>=2)
//  M  32  element width in bits
// PORTS
//  clk        in   1        clock, rising edge
//  rst        in   1        reset, asynchronous, active-high
//  in_valid   in   1        in_data holds a valid element
//  in_ready   out  1        loader accepts an element this cycle
//  in_data    in   M        element value
//  flush      in   1        sync abort: discard the partial or held load, return to LOAD
//  mat_ack    in   1        consumer is finished with the held matrices (one-cycle pulse)
//  x          out  M*N*N    operand X; element (r,c) at bits [M*(N*r+c+1)-1 : M*(N*r+c)]
//  y          out  M*N*N    operand Y; same packing as x
//  mat_valid  out  1        x/y are complete and stable
//  mat_start  out  1        one-cycle pulse on the first cycle mat_valid is high
//  load_cnt   out  IDXW     elements accepted in the current load; IDXW = log2(2*N*N)
// BEHAVIOUR
//  Reset
//   - state=LOAD, idx=0. x, y all zero.
//   - mat_valid=0, mat_start=0, in_ready=0 on the first cycle after release, then 1.
//  States
//   LOAD: in_ready = !flush.
//    - A handshake (in_valid & in_ready) writes in_data to slot idx, then idx+1.
//    - idx 0..N*N-1 fills x row-major. idx N*N..2*N*N-1 fills y row-major.
//    - A handshake at idx=2*N*N-1 sets idx=0 and moves to FULL on the next edge.
//   FULL: in_ready=0, mat_valid=1. mat_start=1 only on the first FULL cycle. x and y are frozen.
//    - mat_ack=1 moves to LOAD on the next edge; mat_valid drops at that edge.
//    - x and y keep their old contents until overwritten slot by slot.
//  Other rules
//   - mat_ack while in LOAD is ignored.
//   - flush (any state) sets idx=0 and state=LOAD on the next edge; no handshake happens that
//     cycle. flush has priority over a concurrent mat_ack. x/y contents are not cleared.
//   - load_cnt = idx. Latency from the last element accepted to mat_valid=1 is one cycle.
//   - No arithmetic is done on data. idx counts only up to 2*N*N-1 and then wraps to 0.
//   - rst during a load aborts immediately and forces the reset values above.
// STRUCTURE
//  - The log2 constant function and the IDXW/slot-index helpers go in a shared include used by
//    the multiplier and the loader: matrix_defs.vh.
//  - Single module, two-state FSM, no sub-module. Slot write enable = one-hot decode of idx.
// TESTING (N=3, M=32)
//  - Reset: rst pulse -> x=y=0, mat_valid=0, mat_start=0, load_cnt=0; in_ready=1 by the
//    second cycle.
//  - Full load: stream 1..18 with in_valid held high.
//    -> x elem(0,0)=1, elem(2,2)=9; y elem(0,0)=10, elem(2,2)=18.
//    -> mat_valid rises 1 cycle after element 18; mat_start high exactly 1 cycle.
//  - Backpressure: in_valid toggling 1/0 during the load -> same packing as the full load.
//    While FULL, in_ready=0 and in_valid=1 with data 0xDEAD leaves x/y unchanged.
//  - Release/reload: mat_ack in FULL -> mat_valid=0 next cycle.
//    Stream 100..117 -> x elem(0,0)=100, y elem(2,2)=117.
//  - Flush: flush after 7 elements -> load_cnt=0, in_ready=0 during the flush cycle.
//    A new 18-element load gives the correct packing. flush with mat_ack in FULL -> LOAD.
//  - Async reset mid-load (after 12 elements): outputs go to reset values without waiting for a
//    clock edge. The next full load completes normally.

Source files
------------

// File: rtl/matrix_stream_loader_pkg.sv
// -----------------------------------------------------------------------------
// matrix_stream_loader_pkg
//   Definitions shared by the matrix multiplier and its stream loader:
//   the loader FSM state encoding, a constant-safe ceil(log2) function and
//   the index-width / slot-position helpers.
//   No ports (package).
// -----------------------------------------------------------------------------
package matrix_stream_loader_pkg;

   typedef enum logic {
      ST_LOAD = 1'b0,   // accepting elements into x/y
      ST_FULL = 1'b1    // both operands complete, held for the consumer
   } state_e;

   // ceil(log2(value)), usable in parameter/localparam expressions.
   function automatic int clog2(input int value);
      int result;
      result = 0;
      while ((1 << result) < value) begin
         result++;
      end
      return result;
   endfunction

   // Width of the element index covering both NxN operands.
   function automatic int idx_width(input int n);
      return clog2(2 * n * n);
   endfunction

   // Bit position of the least significant bit of a slot in a flat bus.
   function automatic int slot_lsb(input int m, input int slot);
      return m * slot;
   endfunction

endpackage

// File: rtl/matrix_stream_loader.sv
// -----------------------------------------------------------------------------
// matrix_stream_loader
//   Upstream stage for the sequential matrix multiplier. Collects 2*N*N M-bit
//   elements from a valid/ready stream into operand X (first N*N elements) and
//   operand Y (next N*N), both row-major, then holds them stable and signals
//   the consumer until it acknowledges.
//
// Parameters
//   N          matrix dimension (N >= 2)
//   M          element width in bits
//
// Ports
//   clk        in   clock, rising edge
//   rst        in   asynchronous, active-high reset
//   in_valid   in   in_data holds a valid element
//   in_ready   out  element accepted this cycle when in_valid is also high
//   in_data    in   element value (M bits)
//   flush      in   synchronous abort of a partial or held load
//   mat_ack    in   consumer has finished with the held operands
//   x          out  operand X, element (r,c) at bits [M*(N*r+c+1)-1 : M*(N*r+c)]
//   y          out  operand Y, same packing as x
//   mat_valid  out  x/y complete and stable
//   mat_start  out  one-cycle pulse on the first mat_valid cycle
//   load_cnt   out  elements accepted so far in the current load
// -----------------------------------------------------------------------------
module matrix_stream_loader
   import matrix_stream_loader_pkg::*;
#(
   parameter  int N    = 3,
   parameter  int M    = 32,
   localparam int IDXW = idx_width(N)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [M-1:0]       in_data,
   input  logic               flush,
   input  logic               mat_ack,
   output logic [M*N*N-1:0]   x,
   output logic [M*N*N-1:0]   y,
   output logic               mat_valid,
   output logic               mat_start,
   output logic [IDXW-1:0]    load_cnt
);

   localparam int SLOTS = 2 * N * N;
   localparam int HALF  = M * N * N;
   localparam logic [IDXW-1:0] LAST_IDX = IDXW'(SLOTS - 1);

   state_e              state_q, state_d;
   logic [IDXW-1:0]     idx_q,   idx_d;
   logic                start_q, start_d;
   logic                ready_q, ready_d;
   logic [2*HALF-1:0]   mat_q,   mat_d;   // y in the upper half, x in the lower
   logic [SLOTS-1:0]    slot_we;
   logic                handshake;

   // ready_q holds in_ready low for the first cycle out of reset.
   assign in_ready  = (state_q == ST_LOAD) && ready_q && !flush;
   assign handshake = in_valid && in_ready;

   // One-hot slot write enable decoded from the element index.
   always_comb begin
      // NOTE: every signal written in always_comb gets a default first, so no
      // path can leave it unassigned and infer a latch.
      slot_we = '0;
      for (int s = 0; s < SLOTS; s++) begin
         slot_we[s] = handshake && (idx_q == IDXW'(s));
      end
   end

   always_comb begin
      mat_d = mat_q;
      for (int s = 0; s < SLOTS; s++) begin
         if (slot_we[s]) begin
            mat_d[slot_lsb(M, s) +: M] = in_data;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      start_d = 1'b0;
      ready_d = 1'b1;
      if (flush) begin
         // Flush wins over mat_ack; stored data is left in place.
         state_d = ST_LOAD;
         idx_d   = '0;
      end else begin
         unique case (state_q)
            ST_LOAD: begin
               if (handshake) begin
                  if (idx_q == LAST_IDX) begin
                     idx_d   = '0;
                     state_d = ST_FULL;
                     start_d = 1'b1;
                  end else begin
                     idx_d = idx_q + IDXW'(1);
                  end
               end
            end
            ST_FULL: begin
               if (mat_ack) begin
                  state_d = ST_LOAD;
               end
            end
            default: state_d = ST_LOAD;
         endcase
      end
   end

   // NOTE: state is updated with non-blocking assignments so every flop
   // samples the pre-edge values of the others.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_LOAD;
         idx_q   <= '0;
         start_q <= 1'b0;
         ready_q <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         start_q <= start_d;
         ready_q <= ready_d;
      end
   end

   // NOTE: the operand storage is reset because x/y are architecturally
   // defined as zero after reset; it is a flat register, not a RAM.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mat_q <= '0;
      end else begin
         mat_q <= mat_d;
      end
   end

   assign x         = mat_q[HALF-1:0];
   assign y         = mat_q[2*HALF-1:HALF];
   assign mat_valid = (state_q == ST_FULL);
   // start_q is only set on the LOAD->FULL edge, so it marks the first FULL cycle.
   assign mat_start = start_q;
   assign load_cnt  = idx_q;

endmodule
